// File: rtl/trng_pkg.sv
// Shared types and helpers for the ring-oscillator TRNG sequencer.
// State encoding plus a counter-width helper.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FAULT
  } trng_state_e;

  // Bits needed to hold the values 0..n-1 (never less than one).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trng_rep_test.sv
// Repetition-count health test on the sampled raw bit.
// Flags a failure when a run of identical samples reaches REP_LIMIT.
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sbit,
  input  logic clear,
  output logic fail
);

  localparam int RUN_W = cnt_w(REP_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(REP_LIMIT);

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic             prev_q;

  // A zero run means no sample seen yet since the last clear.
  always_comb begin
    run_d = run_q;
    if (run_q == '0 || sbit != prev_q) begin
      run_d = RUN_ONE;
    end else begin
      run_d = run_q + 1'b1;
    end
    fail = strobe && !clear && (run_d == RUN_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else if (clear) begin
      run_q  <= '0;
      prev_q <= 1'b0;
    end else if (strobe) begin
      run_q  <= run_d;
      prev_q <= sbit;
    end
  end

endmodule

// File: rtl/trng_sequencer.sv
// Ring-oscillator entropy sequencer: warm-up, sampling, health test,
// optional von Neumann debias, word packing and a one-word buffer.
module trng_sequencer
  import trng_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter int WARMUP_CYCLES = 1024,
  parameter int SAMPLE_DIV    = 8,
  parameter int REP_LIMIT     = 32,
  parameter int DEBIAS        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              raw_bit,
  output logic              osc_enable,
  output logic              rng_clr,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              fault,
  output logic              busy
);

  localparam int WARM_W = cnt_w(WARMUP_CYCLES);
  localparam int DIV_W  = cnt_w(SAMPLE_DIV);
  localparam int BIT_W  = cnt_w(WORD_W + 1);

  localparam logic [WARM_W-1:0] WARM_LAST =
    WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL =
    BIT_W'(WORD_W);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(WORD_W - 1);

  trng_state_e state_q;
  trng_state_e state_d;

  logic [1:0]        sync_q;
  logic              sbit;
  logic [WARM_W-1:0] warm_q;
  logic [DIV_W-1:0]  div_q;
  logic              strobe;
  logic              use_stb;
  logic              rep_fail;
  logic              pair_have;
  logic              pair_a;
  logic              emit;
  logic              emit_bit;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;
  logic [BIT_W-1:0]  bit_q;
  logic              full;
  logic              buf_free;
  logic              fault_q;

  // raw_bit is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_bit};
    end
  end

  assign sbit = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = WARMUP;
        WARMUP:  if (warm_q == WARM_LAST) state_d = COLLECT;
        COLLECT: if (rep_fail) state_d = FAULT;
        FAULT:   if (start) state_d = WARMUP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    osc_enable = 1'b0;
    rng_clr    = 1'b1;
    busy       = 1'b0;
    unique case (state_q)
      WARMUP, COLLECT: begin
        osc_enable = 1'b1;
        rng_clr    = 1'b0;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (state_q == COLLECT && state_d == FAULT) begin
      fault_q <= 1'b1;
    end else if (state_q != WARMUP && state_d == WARMUP) begin
      fault_q <= 1'b0;
    end
  end

  assign fault = fault_q;

  // Counters idle at zero, so entering a state starts them cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q <= '0;
      div_q  <= '0;
    end else begin
      if (state_q == WARMUP) begin
        warm_q <= warm_q + 1'b1;
      end else begin
        warm_q <= '0;
      end
      if (state_q != COLLECT || div_q == DIV_LAST) begin
        div_q <= '0;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  assign strobe   = (state_q == COLLECT) && (div_q == DIV_LAST);
  assign full     = (bit_q == BIT_FULL);
  assign buf_free = !word_valid || word_ready;
  // A completed word waiting for the buffer freezes everything upstream.
  assign use_stb  = strobe && !stop && !full;

  trng_rep_test #(
    .REP_LIMIT(REP_LIMIT)
  ) u_rep (
    .clk   (clk),
    .reset (reset),
    .strobe(use_stb),
    .sbit  (sbit),
    .clear (state_q != COLLECT),
    .fail  (rep_fail)
  );

  always_comb begin
    emit     = 1'b0;
    emit_bit = sbit;
    if (use_stb && !rep_fail) begin
      if (DEBIAS != 0) begin
        if (pair_have && (pair_a != sbit)) begin
          emit     = 1'b1;
          emit_bit = pair_a;
        end
      end else begin
        emit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_have <= 1'b0;
      pair_a    <= 1'b0;
    end else if (state_q != COLLECT) begin
      pair_have <= 1'b0;
      pair_a    <= 1'b0;
    end else if (use_stb) begin
      pair_have <= !pair_have;
      if (!pair_have) begin
        pair_a <= sbit;
      end
    end
  end

  assign shift_d = {shift_q[WORD_W-2:0], emit_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      bit_q      <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (state_q != COLLECT) begin
        bit_q <= '0;
      end else if (full && buf_free && !stop) begin
        word_data  <= shift_q;
        word_valid <= 1'b1;
        bit_q      <= '0;
      end else if (emit) begin
        if (bit_q == BIT_LAST && buf_free) begin
          word_data  <= shift_d;
          word_valid <= 1'b1;
          bit_q      <= '0;
        end else begin
          shift_q <= shift_d;
          bit_q   <= bit_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_sequencer.sv
// Scoreboard bench for trng_sequencer: one raw-packing instance and
// one debiasing instance share the entropy input.
module tb_trng_sequencer;

  localparam int W    = 8;
  localparam int WARM = 16;
  localparam int DIV  = 2;
  localparam int REP  = 8;

  logic clk = 1'b0;
  logic reset;
  logic stop;
  logic raw_bit;
  logic [1:0] start_v;
  logic [1:0] ready_v;
  logic [1:0] osc_v;
  logic [1:0] clr_v;
  logic [1:0] valid_v;
  logic [1:0] fault_v;
  logic [1:0] busy_v;
  logic [1:0][W-1:0] data_v;

  int n_vec;
  int n_err;
  logic [1:0] mon_en;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic raw_q[$];

  always #5 clk = ~clk;

  trng_sequencer #(
    .WORD_W(W), .WARMUP_CYCLES(WARM), .SAMPLE_DIV(DIV),
    .REP_LIMIT(REP), .DEBIAS(0)
  ) u_raw (
    .clk(clk), .reset(reset), .start(start_v[0]), .stop(stop),
    .raw_bit(raw_bit), .osc_enable(osc_v[0]), .rng_clr(clr_v[0]),
    .word_data(data_v[0]), .word_valid(valid_v[0]),
    .word_ready(ready_v[0]), .fault(fault_v[0]), .busy(busy_v[0])
  );

  trng_sequencer #(
    .WORD_W(W), .WARMUP_CYCLES(WARM), .SAMPLE_DIV(DIV),
    .REP_LIMIT(REP), .DEBIAS(1)
  ) u_vn (
    .clk(clk), .reset(reset), .start(start_v[1]), .stop(stop),
    .raw_bit(raw_bit), .osc_enable(osc_v[1]), .rng_clr(clr_v[1]),
    .word_data(data_v[1]), .word_valid(valid_v[1]),
    .word_ready(ready_v[1]), .fault(fault_v[1]), .busy(busy_v[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en[0] && valid_v[0] && ready_v[0]) begin
      if (exp_q0.size() == 0) chk("raw_extra_word", exp_q0.size(), 1);
      else chk("raw_word", data_v[0], exp_q0.pop_front());
    end
    if (mon_en[1] && valid_v[1] && ready_v[1]) begin
      if (exp_q1.size() == 0) chk("vn_extra_word", exp_q1.size(), 1);
      else chk("vn_word", data_v[1], exp_q1.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i);
    start_v[i] = 1'b1;
    @(posedge clk);
    #1 start_v[i] = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) raw_q.push_back(v[k]);
  endtask

  // Each queued bit is held across the synchronizer input for one strobe.
  task automatic feed();
    repeat (WARM - 1) @(posedge clk);
    while (raw_q.size() > 0) begin
      #1 raw_bit = raw_q.pop_front();
      repeat (DIV) @(posedge clk);
    end
    #1;
  endtask

  task automatic wait_valid(input int i, output int cyc);
    cyc = 0;
    while (!valid_v[i] && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("valid_wait", valid_v[i], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    stop    = 1'b0;
    raw_bit = 1'b0;
    start_v = '0;
    ready_v = '0;
    mon_en  = 2'b11;
    tick(3);
    reset = 1'b0;
    tick(20);
    for (int i = 0; i < 2; i++) begin
      chk("rst_osc", osc_v[i], 0);
      chk("rst_clr", clr_v[i], 1);
      chk("rst_valid", valid_v[i], 0);
      chk("rst_fault", fault_v[i], 0);
      chk("rst_busy", busy_v[i], 0);
      chk("rst_data", data_v[i], 0);
    end

    ready_v[0] = 1'b1;
    push_bits(8'hAA, 8);
    exp_q0.push_back(8'hAA);
    do_start(0);
    chk("start_osc", osc_v[0], 1);
    chk("start_clr", clr_v[0], 0);
    chk("start_busy", busy_v[0], 1);
    fork
      feed();
      begin
        wait_valid(0, cyc);
        chk("valid_latency_ok",
            (cyc >= WARM + W * DIV && cyc <= WARM + W * DIV + 4), 1);
      end
    join
    do_stop();
    tick(2);
    chk("raw_drained", exp_q0.size(), 0);
    chk("stop_idle", busy_v[0], 0);

    ready_v[1] = 1'b1;
    push_bits(20'b10011110000110100110, 20);
    exp_q1.push_back(8'hAD);
    do_start(1);
    fork
      feed();
      wait_valid(1, cyc);
    join
    do_stop();
    tick(2);
    chk("vn_drained", exp_q1.size(), 0);

    mon_en[0] = 1'b0;
    raw_bit = 1'b1;
    tick(4);
    do_start(0);
    tick(WARM + REP * DIV - 1);
    chk("pre_fail_fault", fault_v[0], 0);
    chk("pre_fail_busy", busy_v[0], 1);
    tick(1);
    chk("fail_fault", fault_v[0], 1);
    chk("fail_osc", osc_v[0], 0);
    chk("fail_clr", clr_v[0], 1);
    chk("fail_busy", busy_v[0], 0);
    tick(5);
    chk("fault_held", fault_v[0], 1);
    do_start(0);
    chk("restart_fault", fault_v[0], 0);
    chk("restart_osc", osc_v[0], 1);
    chk("restart_busy", busy_v[0], 1);
    do_stop();
    tick(4);
    mon_en[0] = 1'b1;
    raw_bit = 1'b0;
    tick(2);

    ready_v[0] = 1'b0;
    push_bits(8'h3C, 8);
    push_bits(8'h96, 8);
    push_bits(12'hFFF, 12);
    exp_q0.push_back(8'h3C);
    exp_q0.push_back(8'h96);
    do_start(0);
    fork
      feed();
      begin
        wait_valid(0, cyc);
        chk("stall_w1", data_v[0], 8'h3C);
        tick(36);
        chk("stall_valid", valid_v[0], 1);
        chk("stall_hold", data_v[0], 8'h3C);
        chk("stall_busy", busy_v[0], 1);
        chk("stall_nofault", fault_v[0], 0);
        ready_v[0] = 1'b1;
        tick(1);
        ready_v[0] = 1'b0;
        chk("b2b_valid", valid_v[0], 1);
        chk("b2b_w2", data_v[0], 8'h96);
        tick(4);
        do_stop();
        chk("stop_busy", busy_v[0], 0);
        chk("stop_osc", osc_v[0], 0);
        chk("stop_valid", valid_v[0], 1);
        chk("stop_word", data_v[0], 8'h96);
        tick(3);
        chk("idle_hold", data_v[0], 8'h96);
        ready_v[0] = 1'b1;
        tick(2);
        chk("accept_drop", valid_v[0], 0);
        chk("stall_drained", exp_q0.size(), 0);
      end
    join

    push_bits(8'h5B, 8);
    exp_q0.push_back(8'h5B);
    do_start(0);
    fork
      feed();
      wait_valid(0, cyc);
    join
    tick(2);
    do_stop();
    tick(4);
    chk("fresh_drained", exp_q0.size(), 0);
    chk("vn_idle_drained", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trng_sequencer.md
# trng_sequencer

Synchronous controller for the ring-oscillator entropy source. It drives the source's oscillator enable and clear, waits out a warm-up period, and samples the raw bit at a fixed divided rate. It applies a repetition-count health test and optional von Neumann debiasing, then packs accepted bits into words. Each word is handed to one consumer over a valid/ready interface, backed by a single-word output buffer.

## Interface
- WORD_W, 32, output word width (≥2)
- WARMUP_CYCLES, 1024, clk cycles from oscillator enable to first counted sample (≥1)
- SAMPLE_DIV, 8, clk cycles between raw-bit samples (≥2)
- REP_LIMIT, 32, run of identical raw samples that declares a fault (≥2)
- DEBIAS, 1, 1 = von Neumann debias on; 0 = raw samples packed directly

- clk  in  1  system clock (the 5 MHz PLL output)
- reset  in  1  reset, asynchronous, active-high
- start  in  1  pulse; leaves IDLE or FAULT and begins warm-up
- stop  in  1  pulse; returns to IDLE from any state
- raw_bit  in  1  entropy-source output, asynchronous to clk
- osc_enable  out  1  ring-oscillator enable
- rng_clr  out  1  entropy-source sampling-flop clear, active-high
- word_data  out  WORD_W  buffered random word
- word_valid  out  1  word_data holds an unconsumed word
- word_ready  in  1  consumer accepts when word_valid & word_ready
- fault  out  1  health-test failure latched
- busy  out  1  state is WARMUP or COLLECT

## Operation
- raw_bit passes through a 2-flop synchronizer; only its output (sbit) is used.
- States:
  - IDLE: osc_enable=0, rng_clr=1.
  - WARMUP: osc_enable=1, rng_clr=0, warm-up counter runs.
  - COLLECT: sampling active.
  - FAULT: osc_enable=0, rng_clr=1, fault=1.
- Transitions:
  - IDLE→WARMUP on start.
  - WARMUP→COLLECT when the counter reaches WARMUP_CYCLES-1.
  - COLLECT→FAULT on health failure.
  - FAULT→WARMUP on start; fault clears on entry to WARMUP.
  - Any state→IDLE on stop. stop has priority over start and over failure.
- Sample strobe: the divider counts 0..SAMPLE_DIV-1 and is cleared on entering COLLECT. A strobe fires when the count equals SAMPLE_DIV-1. Only strobes in COLLECT are used.
- Repetition test, on every used strobe: run length resets to 1 when sbit differs from the previous sample, otherwise increments. Reaching REP_LIMIT means failure. The first sample after entering COLLECT starts run=1.
- Debias (DEBIAS=1): samples are paired in strobe order (a, b). a≠b emits bit a (10→1, 01→0). 00 and 11 are discarded. With DEBIAS=0, every sample is emitted.
- Packing: shift_reg ← {shift_reg[WORD_W-2:0], bit}. The first emitted bit ends up in word_data[WORD_W-1]. A bit counter tracks fill.
- Buffer: a full shift register loads into word_data and sets word_valid when the buffer is empty or being accepted in the same cycle. Otherwise collection stalls: strobes are ignored, and the run counter and pair state freeze until the buffer is accepted.
- stop and FAULT discard the partial word, the pair state and the run count. A word already in the buffer stays valid until accepted; word_valid never drops without a handshake.

## Timing
- Reset values:
  - osc_enable=0, rng_clr=1, word_valid=0, word_data=0, fault=0, busy=0.
  - State IDLE; all counters 0.
- start→osc_enable=1: 1 cycle. First used strobe: WARMUP_CYCLES+SAMPLE_DIV cycles after the WARMUP entry edge.
- word_valid rises the cycle after the strobe that supplies the WORD_W-th bit, if the buffer is free.
- The handshake is registered. On accept, word_valid falls next cycle unless a completed word loads in that same cycle, in which case it stays high with new data.
- Failure: fault=1 and osc_enable=0 on the cycle after the failing strobe.
- Raw-bit latency: 2 cycles of synchronizer before sampling.

## Structure
- Package trng_pkg: state enum trng_state_e {IDLE, WARMUP, COLLECT, FAULT}, plus a count-width helper function ($clog2-based).
- Sub-module trng_rep_test: holds the run counter and previous sample. Inputs: strobe, bit, clear. Output: fail.
- Synchronizer, divider, debias, packer and buffer are inline in trng_sequencer.

## Test plan
Bench parameters: WORD_W=8, WARMUP_CYCLES=16, SAMPLE_DIV=2, REP_LIMIT=8.
- Reset, then idle 20 cycles → osc_enable=0, rng_clr=1, word_valid=0, fault=0.
- DEBIAS=0, start, raw_bit alternating per strobe starting at 1 → word_data=8'hAA. word_valid rises 16+8·2+2(sync)+1 cycles after start, ±1.
- DEBIAS=1, sample pairs 10,01,11,10,00,01,10,10,01,10 → emitted 1,0,1,0,1,1,0,1, giving word_data=8'hAD.
- raw_bit held 1 in COLLECT → fault=1 and osc_enable=0 after the 8th strobe. A later start clears fault and re-enters WARMUP.
- word_ready=0 through two completed words → first word held stable and collection stalls. Raise word_ready for 1 cycle → second word appears the next cycle with word_valid continuously 1.
- stop mid-word with buffer valid → IDLE next cycle, buffered word still accepted intact. A fresh start produces a word built only from new bits.
